// File: rtl/alu_operand_loader_pkg.sv
// Shared types and constants for the ALU operand loader: frame layout,
// byte-index positions, control-byte tag and loader state encoding.
package alu_operand_loader_pkg;

  typedef logic [7:0] byte_t;
  typedef logic [1:0] sel_t;
  typedef logic [2:0] idx_t;

  localparam int unsigned FRAME_LEN = 32'd5;

  localparam idx_t IDX_A0   = 3'd0;
  localparam idx_t IDX_B0   = 3'd1;
  localparam idx_t IDX_A1   = 3'd2;
  localparam idx_t IDX_B1   = 3'd3;
  localparam idx_t IDX_CTRL = idx_t'(FRAME_LEN - 32'd1);

  localparam logic [3:0] FRAME_TAG = 4'hA;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  function automatic logic tag_ok(input byte_t ctrl);
    return (ctrl[7:4] == FRAME_TAG);
  endfunction

endpackage

// File: rtl/alu_operand_loader_if.sv
// Byte-stream input, operand-set output and status signals of the loader.
// The loader itself uses the slave view; the producer/consumer side uses master.
interface alu_operand_loader_if;
  import alu_operand_loader_pkg::*;

  logic  in_valid;
  byte_t in_data;
  logic  in_ready;
  byte_t A0;
  byte_t B0;
  byte_t A1;
  byte_t B1;
  sel_t  ALU_Sel1;
  sel_t  ALU_Sel2;
  logic  op_valid;
  logic  op_ack;
  logic  frame_err;
  byte_t frames_done;

  modport master (
    output in_valid, in_data, op_ack,
    input  in_ready, A0, B0, A1, B1, ALU_Sel1, ALU_Sel2, op_valid, frame_err, frames_done
  );

  modport slave (
    input  in_valid, in_data, op_ack,
    output in_ready, A0, B0, A1, B1, ALU_Sel1, ALU_Sel2, op_valid, frame_err, frames_done
  );

endinterface

// File: rtl/alu_operand_loader_gap_timer.sv
// Inter-byte idle gap counter. expired is raised on the idle cycle whose
// increment would bring the count to TIMEOUT, so the abort lands at that edge.
module gap_timer #(
  parameter int unsigned TIMEOUT = 32'd16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 32'd1);

  logic [7:0] count_r;

  assign expired = enable && (count_r == LAST_COUNT);

  // Count idle cycles; clear and expiry restart, stalls (no enable) hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 8'd0;
    end else if (clear || expired) begin
      count_r <= 8'd0;
    end else if (enable) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/alu_operand_loader.sv
// Collects 5-byte frames (A0, B0, A1, B1, CTRL) into staging registers and
// publishes a complete, tag-checked operand set to the dual ALU stage.
module alu_operand_loader #(
  parameter int unsigned TIMEOUT = 32'd16
) (
  input logic                 wb_clk_i,
  input logic                 wb_rst_i,
  alu_operand_loader_if.slave bus
);
  import alu_operand_loader_pkg::*;

  state_t state_r;
  state_t state_next_s;
  idx_t   idx_r;
  idx_t   idx_next_s;

  byte_t stage_a0_r;
  byte_t stage_b0_r;
  byte_t stage_a1_r;
  byte_t stage_b1_r;

  byte_t a0_r;
  byte_t b0_r;
  byte_t a1_r;
  byte_t b1_r;
  sel_t  sel1_r;
  sel_t  sel2_r;
  logic  op_valid_r;
  logic  frame_err_r;
  byte_t frames_done_r;

  logic ready_s;
  logic accept_s;
  logic good_ctrl_s;
  logic bad_ctrl_s;
  logic timeout_s;
  logic gap_clear_s;
  logic gap_enable_s;
  logic gap_expired_s;

  // CTRL may only enter when the output slot is free or being freed this cycle.
  assign ready_s      = !((idx_r == IDX_CTRL) && op_valid_r && !bus.op_ack);
  assign accept_s     = bus.in_valid && ready_s;
  assign gap_enable_s = (state_r == LOAD) && !bus.in_valid;
  assign gap_clear_s  = (state_r != LOAD) || accept_s;

  gap_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_gap_timer (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clear  (gap_clear_s),
    .enable (gap_enable_s),
    .expired(gap_expired_s)
  );

  // Frame state and byte-index register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= IDLE;
      idx_r   <= IDX_A0;
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
    end
  end

  // Next-state decode plus frame completion, bad-tag and timeout events.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    good_ctrl_s  = 1'b0;
    bad_ctrl_s   = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = LOAD;
          idx_next_s   = IDX_B0;
        end else begin
          state_next_s = IDLE;
          idx_next_s   = IDX_A0;
        end
      end
      LOAD: begin
        if (accept_s) begin
          if (idx_r == IDX_CTRL) begin
            state_next_s = IDLE;
            idx_next_s   = IDX_A0;
            if (tag_ok(bus.in_data)) begin
              good_ctrl_s = 1'b1;
            end else begin
              bad_ctrl_s  = 1'b1;
            end
          end else begin
            idx_next_s = idx_r + 3'd1;
          end
        end else if (gap_expired_s) begin
          state_next_s = IDLE;
          idx_next_s   = IDX_A0;
          timeout_s    = 1'b1;
        end else begin
          state_next_s = LOAD;
        end
      end
      default: begin
        state_next_s = IDLE;
        idx_next_s   = IDX_A0;
      end
    endcase
  end

  // Capture operand bytes as they are accepted.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stage_a0_r <= 8'h00;
      stage_b0_r <= 8'h00;
      stage_a1_r <= 8'h00;
      stage_b1_r <= 8'h00;
    end else if (accept_s) begin
      case (idx_r)
        IDX_A0:  stage_a0_r <= bus.in_data;
        IDX_B0:  stage_b0_r <= bus.in_data;
        IDX_A1:  stage_a1_r <= bus.in_data;
        IDX_B1:  stage_b1_r <= bus.in_data;
        default: stage_a0_r <= stage_a0_r;
      endcase
    end else begin
      stage_a0_r <= stage_a0_r;
    end
  end

  // Publish a completed frame; a fresh load outranks a same-cycle op_ack.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      a0_r          <= 8'h00;
      b0_r          <= 8'h00;
      a1_r          <= 8'h00;
      b1_r          <= 8'h00;
      sel1_r        <= 2'd0;
      sel2_r        <= 2'd0;
      op_valid_r    <= 1'b0;
      frame_err_r   <= 1'b0;
      frames_done_r <= 8'h00;
    end else begin
      frame_err_r <= bad_ctrl_s || timeout_s;
      if (good_ctrl_s) begin
        a0_r          <= stage_a0_r;
        b0_r          <= stage_b0_r;
        a1_r          <= stage_a1_r;
        b1_r          <= stage_b1_r;
        sel1_r        <= bus.in_data[1:0];
        sel2_r        <= bus.in_data[3:2];
        op_valid_r    <= 1'b1;
        frames_done_r <= frames_done_r + 8'h01;
      end else if (bus.op_ack) begin
        op_valid_r <= 1'b0;
      end else begin
        op_valid_r <= op_valid_r;
      end
    end
  end

  assign bus.in_ready    = ready_s;
  assign bus.A0          = a0_r;
  assign bus.B0          = b0_r;
  assign bus.A1          = a1_r;
  assign bus.B1          = b1_r;
  assign bus.ALU_Sel1    = sel1_r;
  assign bus.ALU_Sel2    = sel2_r;
  assign bus.op_valid    = op_valid_r;
  assign bus.frame_err   = frame_err_r;
  assign bus.frames_done = frames_done_r;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed self-checking bench for alu_operand_loader: inputs change and
// outputs are sampled on the falling clock edge.
module tb_alu_operand_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   start_cyc = 0;

  alu_operand_loader_if bus();

  alu_operand_loader #(
    .TIMEOUT(16)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    #1;
    while (!bus.in_ready && n < 64) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("ready_wait", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a0, input logic [7:0] b0,
                            input logic [7:0] a1, input logic [7:0] b1,
                            input logic [7:0] ctrl);
    send_byte(a0);
    send_byte(b0);
    send_byte(a1);
    send_byte(b1);
    send_byte(ctrl);
  endtask

  initial begin
    logic [7:0] v;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.op_ack   = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_op_valid", bus.op_valid, 0);
    chk("rst_a0", bus.A0, 0);
    chk("rst_sel1", bus.ALU_Sel1, 0);
    chk("rst_frames", bus.frames_done, 0);
    chk("rst_err", bus.frame_err, 0);
    chk("rst_ready", bus.in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // First frame, no ack
    send_frame(8'h12, 8'h34, 8'h56, 8'h78, 8'hA6);
    chk("f1_valid", bus.op_valid, 1);
    chk("f1_a0", bus.A0, 8'h12);
    chk("f1_b0", bus.B0, 8'h34);
    chk("f1_a1", bus.A1, 8'h56);
    chk("f1_b1", bus.B1, 8'h78);
    chk("f1_sel1", bus.ALU_Sel1, 2);
    chk("f1_sel2", bus.ALU_Sel2, 1);
    chk("f1_frames", bus.frames_done, 1);
    chk("f1_err", bus.frame_err, 0);

    // Second frame stalls on CTRL until op_ack
    send_byte(8'h9A);
    send_byte(8'hBC);
    send_byte(8'hDE);
    send_byte(8'hF0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA9;
    #1;
    chk("stall_ready", bus.in_ready, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("stall_ready2", bus.in_ready, 0);
    chk("stall_a0_hold", bus.A0, 8'h12);
    chk("stall_frames", bus.frames_done, 1);
    bus.op_ack = 1'b1;
    #1;
    chk("ack_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op_ack   = 1'b0;
    chk("f2_valid", bus.op_valid, 1);
    chk("f2_a0", bus.A0, 8'h9A);
    chk("f2_b0", bus.B0, 8'hBC);
    chk("f2_a1", bus.A1, 8'hDE);
    chk("f2_b1", bus.B1, 8'hF0);
    chk("f2_sel1", bus.ALU_Sel1, 1);
    chk("f2_sel2", bus.ALU_Sel2, 2);
    chk("f2_frames", bus.frames_done, 2);

    // op_ack clears op_valid; a second ack while idle is ignored
    bus.op_ack = 1'b1;
    @(negedge clk);
    bus.op_ack = 1'b0;
    chk("ack_clear", bus.op_valid, 0);
    chk("ack_a0_hold", bus.A0, 8'h9A);
    bus.op_ack = 1'b1;
    @(negedge clk);
    bus.op_ack = 1'b0;
    chk("ack_idle_valid", bus.op_valid, 0);
    chk("ack_idle_frames", bus.frames_done, 2);

    // Bad tag
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h56);
    chk("bad_err", bus.frame_err, 1);
    chk("bad_valid", bus.op_valid, 0);
    chk("bad_a0", bus.A0, 8'h9A);
    chk("bad_sel1", bus.ALU_Sel1, 1);
    chk("bad_frames", bus.frames_done, 2);
    @(negedge clk);
    chk("bad_err_pulse", bus.frame_err, 0);

    // Timeout after two bytes and 16 idle cycles
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (15) @(negedge clk);
    chk("to_pre_err", bus.frame_err, 0);
    @(negedge clk);
    chk("to_err", bus.frame_err, 1);
    send_frame(8'h21, 8'h43, 8'h65, 8'h87, 8'hA4);
    chk("to_next_valid", bus.op_valid, 1);
    chk("to_next_a0", bus.A0, 8'h21);
    chk("to_next_b0", bus.B0, 8'h43);
    chk("to_next_a1", bus.A1, 8'h65);
    chk("to_next_b1", bus.B1, 8'h87);
    chk("to_next_sel1", bus.ALU_Sel1, 0);
    chk("to_next_sel2", bus.ALU_Sel2, 1);
    chk("to_next_frames", bus.frames_done, 3);

    // Byte on the cycle the counter would reach TIMEOUT wins
    bus.op_ack = 1'b1;
    @(negedge clk);
    bus.op_ack = 1'b0;
    send_byte(8'h31);
    repeat (15) @(negedge clk);
    chk("edge_pre_err", bus.frame_err, 0);
    send_byte(8'h32);
    chk("edge_no_abort", bus.frame_err, 0);
    send_byte(8'h33);
    send_byte(8'h34);
    send_byte(8'hA5);
    chk("edge_valid", bus.op_valid, 1);
    chk("edge_a0", bus.A0, 8'h31);
    chk("edge_b0", bus.B0, 8'h32);
    chk("edge_b1", bus.B1, 8'h34);
    chk("edge_sel1", bus.ALU_Sel1, 1);
    chk("edge_sel2", bus.ALU_Sel2, 1);
    chk("edge_frames", bus.frames_done, 4);

    // Reset mid-frame
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h43);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_a0", bus.A0, 0);
    chk("mrst_b1", bus.B1, 0);
    chk("mrst_sel2", bus.ALU_Sel2, 0);
    chk("mrst_valid", bus.op_valid, 0);
    chk("mrst_frames", bus.frames_done, 0);
    chk("mrst_ready", bus.in_ready, 1);
    send_frame(8'h51, 8'h52, 8'h53, 8'h54, 8'hAB);
    chk("post_rst_a0", bus.A0, 8'h51);
    chk("post_rst_b1", bus.B1, 8'h54);
    chk("post_rst_sel1", bus.ALU_Sel1, 3);
    chk("post_rst_sel2", bus.ALU_Sel2, 2);
    chk("post_rst_frames", bus.frames_done, 1);

    // 255 back-to-back frames with op_ack held: full rate and counter wrap
    bus.op_ack = 1'b1;
    start_cyc = cyc;
    for (int i = 0; i < 255; i++) begin
      v = 8'(i);
      send_frame(v, ~v, v + 8'd1, 8'h5A, {4'hA, v[3:0]});
    end
    chk("b2b_cycles", cyc - start_cyc, 1275);
    chk("wrap_frames", bus.frames_done, 0);
    chk("wrap_valid", bus.op_valid, 1);
    chk("wrap_a0", bus.A0, 8'hFE);
    chk("wrap_b0", bus.B0, 8'h01);
    chk("wrap_a1", bus.A1, 8'hFF);
    chk("wrap_sel1", bus.ALU_Sel1, 2);
    chk("wrap_sel2", bus.ALU_Sel2, 3);
    @(negedge clk);
    bus.op_ack = 1'b0;
    chk("wrap_ack_clear", bus.op_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
